// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4
   } fifo_issue_state_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Power-of-two synchronous FIFO with registered occupancy counter.
// Full/empty come from the registered count, so they lag the causing event by one cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_wr_en,
   input  logic             i_rd_en,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_count,
   output logic             o_overflow
);

   localparam logic [AW:0] L_FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_overflow;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   assign w_full  = (r_count == L_FULL_CNT);
   assign w_empty = (r_count == '0);
   // A pop in the same cycle never frees room for a write: the full flag is the registered one.
   assign w_push  = i_wr_en & ~w_full & ~i_flush;
   assign w_pop   = i_rd_en & ~w_empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= i_wr_en & w_full & ~i_flush;
         if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + (AW+1)'(1);
               2'b01:   r_count <= r_count - (AW+1)'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   assign o_rd_data  = r_mem[r_rd_ptr];
   assign o_full     = w_full;
   assign o_empty    = w_empty;
   assign o_count    = r_count;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter one frame at a time over valid/busy/done.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a byte; pops the head and raises o_tx_valid
// ISSUE     | o_tx_valid high for this single cycle
// WAIT_BUSY | waiting for the transmitter to report busy (or an early done)
// WAIT_DONE | frame in progress, waiting for done
// GAP       | transmitter post-stop cleanup cycle; nothing may be issued
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [UART_DATA_W-1:0] i_wr_data,
   input  logic                   i_wr_en,
   input  logic                   i_flush,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [AW:0]            o_count,
   output logic                   o_overflow,
   output logic [UART_DATA_W-1:0] o_tx_data,
   output logic                   o_tx_valid,
   input  logic                   i_tx_busy,
   input  logic                   i_tx_done,
   output logic                   o_idle
);

   fifo_issue_state_t      r_state;
   logic [UART_DATA_W-1:0] r_tx_data;
   logic                   r_tx_valid;

   logic [UART_DATA_W-1:0] w_head;
   logic                   w_empty;
   logic                   w_pop;

   assign w_pop = (r_state == IDLE) & ~w_empty;

   sync_fifo #(
      .WIDTH (UART_DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_data  (i_wr_data),
      .i_wr_en    (i_wr_en),
      .i_rd_en    (w_pop),
      .i_flush    (i_flush),
      .o_rd_data  (w_head),
      .o_full     (o_full),
      .o_empty    (w_empty),
      .o_count    (o_count),
      .o_overflow (o_overflow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
      end else begin
         r_tx_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_tx_data  <= w_head;
                  r_tx_valid <= 1'b1;
                  r_state    <= ISSUE;
               end
            end
            ISSUE: begin
               r_state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               // A done seen before busy is taken as the end of the frame.
               if (i_tx_done) begin
                  r_state <= GAP;
               end else if (i_tx_busy) begin
                  r_state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (i_tx_done) begin
                  r_state <= GAP;
               end
            end
            GAP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state    <= IDLE;
               r_tx_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_empty    = w_empty;
   assign o_tx_data  = r_tx_data;
   assign o_tx_valid = r_tx_valid;
   assign o_idle     = w_empty & (r_state == IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo with a queue-based reference model and a UART transmitter model.
module tb_uart_tx_fifo;

   localparam int DEPTH = 4;
   localparam int AW    = $clog2(DEPTH);
   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    i_wr_data = 8'h00;
   logic          i_wr_en = 1'b0;
   logic          i_flush = 1'b0;
   logic          o_full;
   logic          o_empty;
   logic [AW:0]   o_count;
   logic          o_overflow;
   logic [7:0]    o_tx_data;
   logic          o_tx_valid;
   logic          tx_busy;
   logic          tx_done;
   logic          o_idle;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_data  (i_wr_data),
      .i_wr_en    (i_wr_en),
      .i_flush    (i_flush),
      .o_full     (o_full),
      .o_empty    (o_empty),
      .o_count    (o_count),
      .o_overflow (o_overflow),
      .o_tx_data  (o_tx_data),
      .o_tx_valid (o_tx_valid),
      .i_tx_busy  (tx_busy),
      .i_tx_done  (tx_done),
      .o_idle     (o_idle)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Transmitter model: accepts a byte on valid when idle, busy for FRAME cycles, then pulses done.
   logic       m_busy;
   logic       m_done;
   int         m_cnt;
   logic       stall = 1'b0;
   logic [7:0] rx_q[$];

   assign tx_busy = m_busy | stall;
   assign tx_done = m_done;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_cnt  <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_cnt != 0) begin
            if (!stall) begin
               m_cnt <= m_cnt - 1;
               if (m_cnt == 1) begin
                  m_busy <= 1'b0;
                  m_done <= 1'b1;
               end
            end
         end else if (o_tx_valid) begin
            m_busy <= 1'b1;
            m_cnt  <= FRAME;
            rx_q.push_back(o_tx_data);
         end
      end
   end

   // Inputs as seen by the DUT at each rising edge.
   int         cyc = 0;
   logic       s_wr = 1'b0;
   logic       s_flush = 1'b0;
   logic [7:0] s_data = 8'h00;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      s_wr    <= i_wr_en;
      s_flush <= i_flush;
      s_data  <= i_wr_data;
   end

   // Reference model: queue of stored bytes, popped whenever an issue is observed.
   logic [7:0] q[$];
   int         n_push = 0;
   int         n_valid = 0;
   int         n_ovf_seen = 0;
   int         last_done = -100;
   logic       prev_v = 1'b0;
   logic [7:0] last_issued = 8'h00;
   logic       exp_ovf;

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         last_done   = -100;
         prev_v      = 1'b0;
         last_issued = 8'h00;
      end else begin
         exp_ovf = 1'b0;
         if (s_flush) begin
            q.delete();
         end else if (s_wr) begin
            if (q.size() == DEPTH) begin
               exp_ovf = 1'b1;
            end else begin
               q.push_back(s_data);
               n_push++;
            end
         end
         if (o_tx_valid) begin
            n_valid++;
            chk("valid_single_cycle", prev_v, 0);
            chk("valid_gap_after_done", (cyc - last_done >= 2), 1);
            chk("valid_while_busy", tx_busy, 0);
            if (q.size() == 0) begin
               chk("issue_from_empty", 0, 1);
            end else begin
               last_issued = q.pop_front();
            end
         end
         chk("tx_data", o_tx_data, last_issued);
         prev_v = o_tx_valid;
         if (tx_done) last_done = cyc;
         if (o_overflow) n_ovf_seen++;
         chk("count", o_count, q.size());
         chk("count_le_depth", (o_count <= DEPTH), 1);
         chk("full", o_full, (q.size() == DEPTH));
         chk("empty", o_empty, (q.size() == 0));
         chk("overflow", o_overflow, exp_ovf);
      end
   end

   task automatic wr_on(input logic [7:0] d);
      @(posedge clk); #1;
      i_wr_en   = 1'b1;
      i_wr_data = d;
   endtask

   task automatic wr_off();
      @(posedge clk); #1;
      i_wr_en = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      repeat (2) @(negedge clk);
      while (!(o_idle && !tx_busy && !tx_done) && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("idle_timeout", (k < budget), 1);
   endtask

   task automatic wait_busy(input int budget);
      int k;
      k = 0;
      while (!tx_busy && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("busy_timeout", (k < budget), 1);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_full"}, o_full, 0);
      chk({tag, "_empty"}, o_empty, 1);
      chk({tag, "_count"}, o_count, 0);
      chk({tag, "_overflow"}, o_overflow, 0);
      chk({tag, "_tx_data"}, o_tx_data, 0);
      chk({tag, "_tx_valid"}, o_tx_valid, 0);
      chk({tag, "_idle"}, o_idle, 1);
   endtask

   initial begin
      int rx0, p0, v0, o0;
      logic [7:0] b;

      repeat (3) @(posedge clk);
      #1;
      chk_reset_values("rst");
      rst_n = 1'b1;

      // Single byte: latency and frame completion.
      rx0 = rx_q.size();
      wr_on(8'h55);
      wr_off();
      @(negedge clk);
      chk("lat_valid_early", o_tx_valid, 0);
      chk("lat_empty_fall", o_empty, 0);
      @(negedge clk);
      chk("lat_valid", o_tx_valid, 1);
      chk("lat_data", o_tx_data, 8'h55);
      wait_idle(200);
      chk("t1_sent", rx_q.size() - rx0, 1);
      chk("t1_rx", rx_q[rx_q.size()-1], 8'h55);
      chk("t1_idle", o_idle, 1);

      // Back-to-back burst 0x01..0x05.
      rx0 = rx_q.size();
      for (int i = 1; i <= 5; i++) wr_on(8'(i));
      wr_off();
      wait_idle(600);
      chk("t2_sent", rx_q.size() - rx0, 5);
      for (int i = 0; i < 5; i++) chk("t2_order", rx_q[rx0 + i], i + 1);

      // Stalled transmitter: FIFO saturates, two writes dropped.
      rx0 = rx_q.size();
      wr_on(8'hEE);
      wr_off();
      wait_busy(20);
      @(posedge clk); #1;
      stall = 1'b1;
      o0 = n_ovf_seen;
      for (int i = 0; i < 6; i++) wr_on(8'($urandom_range(0, 255)));
      wr_off();
      repeat (2) @(negedge clk);
      chk("t3_count_sat", o_count, DEPTH);
      chk("t3_full", o_full, 1);
      chk("t3_ovf_pulses", n_ovf_seen - o0, 2);
      @(posedge clk); #1;
      stall = 1'b0;
      wait_idle(800);
      chk("t3_sent", rx_q.size() - rx0, 5);

      // Flush with one byte in flight and two queued.
      rx0 = rx_q.size();
      v0  = n_valid;
      for (int i = 0; i < 3; i++) wr_on(8'($urandom_range(0, 255)));
      wr_off();
      wait_busy(20);
      @(posedge clk); #1;
      i_flush = 1'b1;
      @(posedge clk); #1;
      i_flush = 1'b0;
      @(negedge clk);
      chk("t4_count", o_count, 0);
      chk("t4_empty", o_empty, 1);
      wait_idle(200);
      chk("t4_sent", rx_q.size() - rx0, 1);
      chk("t4_valids", n_valid - v0, 1);

      // 2*DEPTH+3 writes with random spacing while draining.
      rx0 = rx_q.size();
      p0  = n_push;
      for (int i = 0; i < 2 * DEPTH + 3; i++) begin
         wr_on(8'($urandom_range(0, 255)));
         wr_off();
         repeat ($urandom_range(0, 45)) @(posedge clk);
      end
      wait_idle(1200);
      chk("t5_sent", rx_q.size() - rx0, n_push - p0);

      // Random write traffic.
      rx0 = rx_q.size();
      p0  = n_push;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         i_wr_en   = ($urandom_range(0, 1) == 1);
         i_wr_data = 8'($urandom_range(0, 255));
      end
      wr_off();
      wait_idle(1500);
      chk("t6_sent", rx_q.size() - rx0, n_push - p0);

      // Reset while a frame is in progress, then resume.
      wr_on(8'h3C);
      wr_off();
      wait_busy(20);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_values("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      rx0 = rx_q.size();
      wr_on(8'hA3);
      wr_off();
      wait_idle(200);
      chk("t7_sent", rx_q.size() - rx0, 1);
      chk("t7_rx", rx_q[rx_q.size()-1], 8'hA3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and issue controller placed directly upstream of the UART transmitter. It accepts bytes from the system side at full clock rate, stores them in a power-of-two FIFO, and feeds them one at a time to the UART transmitter using that transmitter's `valid`/`busy`/`done` handshake. It guarantees that no byte is offered while the transmitter is mid-frame or in its post-stop cleanup cycle.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in bytes. Must be a power of two and at least 2.
- `AW`, `$clog2(DEPTH)`: pointer width. Derived; not overridden.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `i_wr_data`, in, 8: byte to enqueue.
- `i_wr_en`, in, 1: write strobe, one byte per cycle.
- `i_flush`, in, 1: synchronous FIFO clear.
- `o_full`, out, 1: FIFO holds `DEPTH` bytes.
- `o_empty`, out, 1: FIFO holds 0 bytes.
- `o_count`, out, AW+1: current occupancy.
- `o_overflow`, out, 1: one-cycle pulse when a write is dropped.
- `o_tx_data`, out, 8: byte driven to transmitter `i_tx_data`.
- `o_tx_valid`, out, 1: one-cycle issue pulse to transmitter `i_valid`.
- `i_tx_busy`, in, 1: transmitter `o_busy`.
- `i_tx_done`, in, 1: transmitter `o_done`.
- `o_idle`, out, 1: FIFO empty and FSM in `IDLE`.

## Operation
- Reset values: `o_full` 0, `o_empty` 1, `o_count` 0, `o_overflow` 0, `o_tx_data` 0x00, `o_tx_valid` 0, `o_idle` 1. Pointers are 0. FSM is in `IDLE`.
- Write: accepted only when `o_full` is 0, as registered at the start of the cycle. A write while full is dropped and `o_overflow` pulses. A same-cycle pop does not rescue it.
- Pointers: `wr_ptr` and `rd_ptr` are AW bits wide and wrap naturally modulo `DEPTH`. `o_count` is a registered counter: +1 on write, −1 on pop, unchanged when both occur.
- FSM states and transitions:
  - `IDLE`: if FIFO is not empty, pop the head into `o_tx_data`, assert `o_tx_valid`, and go to `ISSUE`.
  - `ISSUE`: `o_tx_valid` is high for exactly this cycle. Go to `WAIT_BUSY`.
  - `WAIT_BUSY`: when `i_tx_busy` is 1, go to `WAIT_DONE`. If `i_tx_done` arrives here, treat it as `WAIT_DONE`.
  - `WAIT_DONE`: on `i_tx_done`, go to `GAP`.
  - `GAP`: one cycle, covering the transmitter cleanup cycle. Go to `IDLE`.
- Flush: sets pointers and count to 0 and forces `o_empty`. A write in the same cycle as a flush is discarded, with no overflow pulse. An in-flight byte (states `ISSUE` through `GAP`) completes normally. Flush never drops `o_tx_valid` mid-pulse.
- The `default` FSM branch returns to `IDLE` with `o_tx_valid` 0.
- Reset mid-frame: all state returns to reset values immediately. The transmitter is reset by the same `rst_n`.

## Timing
- Write to `o_empty` falling: 1 cycle.
- Write into empty FIFO while FSM is in `IDLE`: `o_tx_valid` high 2 cycles after the write edge (1 cycle to store, 1 cycle to pop/issue).
- Back-to-back bytes: next `o_tx_valid` no earlier than 2 cycles after the `i_tx_done` pulse. This keeps the FIFO clear of the transmitter cleanup cycle.
- `o_tx_data` is stable from the `ISSUE` cycle until the next pop.
- `o_full` and `o_empty` are derived from the registered `o_count` and update the cycle after the causing event.

## Structure
- Shared package `uart_pkg` holds:
  - the `fifo_issue_state_t` enum (3 bits: `IDLE`, `ISSUE`, `WAIT_BUSY`, `WAIT_DONE`, `GAP`);
  - a `UART_DATA_W = 8` constant.
- Sub-module `sync_fifo` (parameters `WIDTH`, `DEPTH`) carries the storage, pointers, count, and full/empty/overflow logic. The top level holds the issue FSM.

## Test plan
- After reset, write 0x55: `o_tx_valid` pulses once with `o_tx_data` = 0x55. A transmitter model (CLKS_PER_BIT = 4) completes the frame and `o_idle` returns to 1.
- Burst-write 0x01–0x05 on consecutive cycles: the transmitter receives 0x01…0x05 in order. Each `o_tx_valid` is at least 2 cycles after the prior `i_tx_done`.
- With DEPTH = 4, transmitter stalled (busy held 1), write 6 bytes: `o_count` saturates at 4, `o_full` = 1, `o_overflow` pulses twice, and only the first 4 bytes are later sent.
- Fill to 3 bytes, first byte in flight, assert `i_flush`: the in-flight byte finishes, `o_count` = 0, and no further `o_tx_valid` occurs.
- Write for 2×DEPTH + 3 bytes while draining: pointer wrap-around preserves order and `o_count` never exceeds `DEPTH`.
- Deassert `rst_n` during `WAIT_DONE`: all outputs take their reset values asynchronously. After release, a new write of 0xA3 is sent correctly.
